// File: rtl/ip_hdr_checker.sv
// IPv4 header checker: captures header fields from the word strobes, checks the
// header checksum (IP_CHECKSUM_CHECK_EN), precomputes TTL/checksum rewrite, queues results.
module ip_hdr_checker #(
    parameter int DATA_WIDTH           = 64,
    parameter int INFO_FIFO_DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  word_ETH_IP_VER,
    input  logic                  word_IP_LEN_ID,
    input  logic                  word_IP_FRAG_TTL_PROTO,
    input  logic                  word_IP_CHECKSUM_SRC_HI,
    input  logic                  word_IP_SRC_DST,
    input  logic                  word_IP_DST_LO,
    input  logic                  rd_ip_info,
    output logic                  ip_info_vld,
    output logic [31:0]           dst_ip,
    output logic                  is_ipv4,
    output logic                  hdr_ok,
    output logic                  has_options,
    output logic                  ttl_expired,
    output logic [7:0]            new_ttl,
    output logic [15:0]           new_checksum,
    output logic                  info_fifo_full,
    output logic                  info_overflow
);

    localparam int DEPTH = 1 << INFO_FIFO_DEPTH_BITS;

    typedef logic [INFO_FIFO_DEPTH_BITS-1:0] ptr_t;
    typedef logic [INFO_FIFO_DEPTH_BITS:0]   cnt_t;

    typedef struct packed {
        logic [31:0] dst_ip;
        logic        is_ipv4;
        logic        hdr_ok;
        logic        has_options;
        logic        ttl_expired;
        logic [7:0]  new_ttl;
        logic [15:0] new_checksum;
    } info_t;

    logic [15:0] ethertype;
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  ttl;
    logic [15:0] checksum;
    logic [15:0] dst_hi;
    logic [15:0] dst_lo;
    logic        fold_vld;
    logic        chk_ok;

    // The two companion strobes and the unused header bits carry nothing we need.
    logic unused_inputs;
    assign unused_inputs = ^{word_IP_FRAG_TTL_PROTO, word_IP_SRC_DST, in_data};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ethertype <= '0;
            version   <= '0;
            ihl       <= '0;
            ttl       <= '0;
            checksum  <= '0;
            dst_hi    <= '0;
            dst_lo    <= '0;
            fold_vld  <= 1'b0;
        end else begin
            if (word_ETH_IP_VER) begin
                ethertype <= in_data[31:16];
                version   <= in_data[15:12];
                ihl       <= in_data[11:8];
            end
            if (word_IP_LEN_ID)
                ttl <= in_data[15:8];
            if (word_IP_CHECKSUM_SRC_HI) begin
                checksum <= in_data[63:48];
                dst_hi   <= in_data[15:0];
            end
            if (word_IP_DST_LO)
                dst_lo <= in_data[63:48];
            fold_vld <= word_IP_DST_LO;
        end
    end

`ifdef IP_CHECKSUM_CHECK_EN
    logic [19:0] acc;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // Word1 loads rather than adds, so a stale partial sum never leaks into the next packet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (word_ETH_IP_VER) begin
            acc <= 20'(in_data[15:0]);
        end else if (word_IP_LEN_ID || word_IP_CHECKSUM_SRC_HI) begin
            acc <= acc + 20'(in_data[63:48]) + 20'(in_data[47:32])
                       + 20'(in_data[31:16]) + 20'(in_data[15:0]);
        end else if (word_IP_DST_LO) begin
            acc <= acc + 20'(in_data[63:48]);
        end
    end

    assign fold1  = {1'b0, acc[15:0]} + 17'(acc[19:16]);
    assign fold2  = fold1[15:0] + 16'(fold1[16]);
    assign chk_ok = (fold2 == 16'hFFFF);
`else
    assign chk_ok = 1'b1;
`endif

    // Decrementing TTL (high byte of the TTL/proto word) raises the stored one's-complement sum by 0x0100.
    logic [16:0] csum_inc;
    info_t       rec;

    assign csum_inc = {1'b0, checksum} + 17'h00100;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rec              = '0;
        rec.dst_ip       = {dst_hi, dst_lo};
        rec.is_ipv4      = (ethertype == 16'h0800) && (version == 4'd4);
        rec.hdr_ok       = chk_ok;
        rec.has_options  = (ihl != 4'd5);
        rec.ttl_expired  = (ttl <= 8'd1);
        rec.new_ttl      = (ttl == 8'd0) ? 8'd0 : ttl - 8'd1;
        rec.new_checksum = (ttl == 8'd0) ? checksum
                                         : csum_inc[15:0] + 16'(csum_inc[16]);
    end

    info_t mem [DEPTH];
    ptr_t  wr_ptr;
    ptr_t  rd_ptr;
    cnt_t  count;
    logic  fifo_empty;
    logic  pop;
    logic  wr_en;
    logic  drop;
    info_t head;

    assign fifo_empty     = (count == '0);
    assign info_fifo_full = (count == cnt_t'(DEPTH));
    assign ip_info_vld    = !fifo_empty;
    assign pop            = rd_ip_info && !fifo_empty;
    assign wr_en          = fold_vld && (!info_fifo_full || pop);
    assign drop           = fold_vld && info_fifo_full && !pop;

    // NOTE: the record storage is not reset; the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= rec;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            info_overflow <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)
                rd_ptr <= rd_ptr + ptr_t'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
            info_overflow <= drop;
        end
    end

    assign head         = fifo_empty ? '0 : mem[rd_ptr];
    assign dst_ip       = head.dst_ip;
    assign is_ipv4      = head.is_ipv4;
    assign hdr_ok       = head.hdr_ok;
    assign has_options  = head.has_options;
    assign ttl_expired  = head.ttl_expired;
    assign new_ttl      = head.new_ttl;
    assign new_checksum = head.new_checksum;

endmodule
